// File: rtl/mem_1rw_pkg.sv
// Shared definitions for the 1RW memory initiator: FSM encoding and response FIFO depth.
package mem_1rw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/mem_1rw_rsp_fifo.sv
// Small synchronous FIFO holding {rd_last, rd_data} response entries.
// A pop frees the head in the same cycle, so a push into a full FIFO is accepted when it coincides with a pop.
module mem_1rw_rsp_fifo
  import mem_1rw_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [W-1:0]  entry_q [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(RSP_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = entry_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) entry_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_1rw_master.sv
// Burst initiator for a single-port 1RW memory: command, write-beat and read-response channels.
// Optional command range check enabled by defining MEM_1RW_MASTER_RANGE_CHK_EN.
//
// Every channel is valid/ready: a beat transfers on the cycle where valid & ready are both high,
// and the sender holds valid and payload stable until then.
module mem_1rw_master
  import mem_1rw_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int WORD_BYTES = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [WORD_BYTES-1:0]   cmd_be,
  output logic                    cmd_err,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [8*WORD_BYTES-1:0] rd_data,
  output logic                    rd_last,
  output logic                    busy,
  output logic                    mem_ce,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wr_data,
  output logic [WORD_BYTES-1:0]   mem_be,
  input  logic [8*WORD_BYTES-1:0] mem_rd_data
);

  localparam int DW = 8 * WORD_BYTES;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    beat_q;
  logic [WORD_BYTES-1:0]   be_q;
  logic                    inflight_q;
  logic                    inflight_last_q;
  logic                    cmd_err_q;

  logic                    cmd_fire;
  logic                    cmd_bad;
  logic                    wr_fire;
  logic                    rd_issue;
  logic                    rsp_pop;
  logic                    beat_last;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [1:0]              occ;
  logic [DW:0]             fifo_head;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign wr_ready  = rst_n & (state_q == ST_WRITE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign wr_fire   = wr_valid & wr_ready;
  assign rsp_pop   = ~fifo_empty & rd_ready;
  assign beat_last = (beat_q == len_q);
  assign cmd_err   = cmd_err_q;

  // Issue only if the beat is guaranteed a FIFO slot when it returns next cycle.
  assign occ      = {fifo_full, ~fifo_full & ~fifo_empty};
  assign rd_issue = rst_n && (state_q == ST_READ) &&
                    (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, rsp_pop}));

  assign mem_ce      = wr_fire | rd_issue;
  assign mem_we      = wr_fire;
  assign mem_addr    = mem_ce ? addr_q : '0;
  assign mem_be      = wr_fire ? be_q : '0;
  assign mem_wr_data = wr_fire ? wr_data : '0;

`ifdef MEM_1RW_MASTER_RANGE_CHK_EN
  logic [ADDR_WIDTH:0] end_addr;
  assign end_addr = {1'b0, cmd_addr} + (ADDR_WIDTH + 1)'(cmd_len);
  assign cmd_bad  = (end_addr >= (ADDR_WIDTH + 1)'(MEM_DEPTH));
`else
  assign cmd_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      be_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      cmd_err_q       <= 1'b0;
    end else begin
      cmd_err_q       <= 1'b0;
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue & beat_last;
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (cmd_bad) begin
              cmd_err_q <= 1'b1;
            end else begin
              addr_q  <= cmd_addr;
              len_q   <= cmd_len;
              be_q    <= cmd_be;
              beat_q  <= '0;
              state_q <= cmd_we ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (wr_fire) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            beat_q <= beat_q + LEN_WIDTH'(1);
            if (beat_last) state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            beat_q <= beat_q + LEN_WIDTH'(1);
            if (beat_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!inflight_q && fifo_empty) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // mem_rd_data is only captured on the cycle after an issue.
  mem_1rw_rsp_fifo #(
    .W (DW + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({inflight_last_q, mem_rd_data}),
    .pop       (rsp_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_valid = ~fifo_empty;
  assign rd_data  = fifo_head[DW-1:0];
  assign rd_last  = fifo_head[DW] & ~fifo_empty;

endmodule

// File: doc/mem_1rw_master.md
Name: mem_1rw_master

Overview:
Initiator side of the single-port 1RW memory interface (ce/we/addr/be/wr_data, rd_data one cycle after a read).
- Accepts burst commands on a valid/ready channel.
- Streams write beats in, and returns read beats on a back-pressurable response channel.
- Sits between a processor/DMA-style client and one 1RW memory instance.

Parameters:
ADDR_WIDTH, 8, memory address width.
MEM_DEPTH, 256, number of implemented words (<= 2^ADDR_WIDTH); used only by the optional range check.
WORD_BYTES, 8, data width = 8*WORD_BYTES bits.
LEN_WIDTH, 4, burst length field width; a burst is cmd_len+1 beats (1..2^LEN_WIDTH).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous reset, active low.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_we  in  1  1 = write burst, 0 = read burst.
cmd_addr  in  ADDR_WIDTH  start address.
cmd_len  in  LEN_WIDTH  beats minus one.
cmd_be  in  WORD_BYTES  byte enables for every beat of a write burst.
cmd_err  out  1  one-cycle error pulse (optional feature; tied 0 otherwise).
wr_valid  in  1  write beat valid.
wr_ready  out  1  write beat accepted.
wr_data  in  8*WORD_BYTES  write beat data.
rd_valid  out  1  read beat valid.
rd_ready  in  1  read beat accepted.
rd_data  out  8*WORD_BYTES  read beat data.
rd_last  out  1  marks the final beat of a read burst.
busy  out  1  high when state is not IDLE.
mem_ce, mem_we  out  1 each  memory chip enable and write enable.
mem_addr  out  ADDR_WIDTH  memory address.
mem_wr_data  out  8*WORD_BYTES  memory write data.
mem_be  out  WORD_BYTES  memory byte enables.
mem_rd_data  in  8*WORD_BYTES  memory read data, valid the cycle after a read issue, X otherwise.

Behaviour:
- One clock `clk`. Reset is synchronous, active-low `rst_n`.
- Reset values:
  - State IDLE; cmd_ready=1, wr_ready=0, rd_valid=0, rd_last=0, busy=0, cmd_err=0.
  - mem_ce=0, mem_we=0.
  - Response buffer empty, in-flight flag cleared.
- Reset mid-burst abandons the burst immediately. Buffered read data is discarded; no further memory access is issued.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch addr, len, be and we; beat counter=0.
  - Go to WRITE if cmd_we, else READ.
- WRITE:
  - wr_ready=1.
  - Each wr_valid&wr_ready cycle drives mem_ce=1, mem_we=1, mem_addr=current, mem_wr_data=wr_data, mem_be=latched be, combinationally in that same cycle.
  - Address increments after each beat.
  - After beat cmd_len, go to IDLE.
  - A stall on wr_valid=0 issues no access.
- READ:
  - Issues mem_ce=1, mem_we=0 when (buffer occupancy + in-flight − pop this cycle) < 2.
  - This sustains 1 beat/cycle while rd_ready=1 and never overflows.
  - The in-flight flag is set on issue. The next cycle, mem_rd_data is pushed into the 2-entry response FIFO.
  - After issuing the final beat, go to DRAIN.
- DRAIN:
  - No issues.
  - Go to IDLE once the in-flight flag is clear and the FIFO is empty.
- Response channel:
  - rd_valid = FIFO not empty; rd_data and rd_last come from the FIFO head.
  - rd_last is set on the entry of beat cmd_len.
  - rd_data is held stable while rd_valid & ~rd_ready.
- Addresses increment modulo 2^ADDR_WIDTH (wrap to 0).
- mem_rd_data is never sampled except on the cycle after a read issue.
- When mem_ce=0, mem_we/mem_addr/mem_be are driven 0.
- Simultaneous FIFO push and pop in the same cycle keeps occupancy unchanged.
- cmd_ready=0 in every state but IDLE. Commands are never overlapped.

Optional Feature:
MEM_1RW_MASTER_RANGE_CHK_EN
- Defined: a command with cmd_addr+cmd_len >= MEM_DEPTH (evaluated in ADDR_WIDTH+1 bits) is accepted but rejected.
  - cmd_err pulses one cycle after the handshake.
  - No memory access, no write beats consumed, no read beats returned; FSM stays IDLE.
- Not defined: cmd_err is constant 0 and addresses wrap as above.

Decomposition:
- Shared package/header mem_1rw_pkg holds:
  - FSM state encoding (IDLE=2'd0, WRITE=2'd1, READ=2'd2, DRAIN=2'd3).
  - The response FIFO depth constant RSP_DEPTH=2.
- Sub-module mem_1rw_rsp_fifo: 2-entry synchronous FIFO of {rd_last, rd_data}, with push/pop/full/empty and synchronous active-low reset.

Test Plan:
1. Write burst addr=0x10, len=3, be=all ones, data 0xA0..0xA3 with wr_valid continuous -> 4 consecutive mem writes to 0x10..0x13; then read of the same range returns 0xA0..0xA3, rd_last on the 4th beat.
2. Read len=7 with rd_ready toggling 1/0 each cycle -> exactly 8 beats in order, no loss or duplication, FIFO never exceeds 2, mem_ce never issues when full.
3. Write addr=0xFE, len=3 -> accesses 0xFE, 0xFF, 0x00, 0x01 (wrap); with RANGE_CHK_EN and MEM_DEPTH=256 -> cmd_err=1 one cycle, no mem_ce.
4. Write be=0x01 over word 0x1122334455667788 with data 0xFF..FF -> readback 0x11223344556677FF.
5. rst_n=0 asserted mid read burst (after 2 beats, FIFO full) -> next cycle rd_valid=0, mem_ce=0, busy=0, cmd_ready=1; a new command proceeds normally.
